instruction_fetch_unit: RTL

- Front-end stage directly upstream of load_store_unit.
- Fetches one 32-bit instruction at a time over its own Wishbone master port.
- Presents each instruction to the downstream execute/LSU path with a one-cycle o_instruction_valid pulse, and honours the LSU stall.
- Supports PC redirect for taken branches/jumps.

---
 rtl/instruction_fetch_unit_if.sv | 21 ++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Wishbone instruction-bus interface shared by the fetch unit and its slave.
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic [3:0]  select;
  logic [31:0] address;
  logic        write_enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output cycle, strobe, select, address, write_enable, data_in,
    input  data_out, ack
  );

  modport slave (
    input  cycle, strobe, select, address, write_enable, data_in,
    output data_out, ack
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one Wishbone read per instruction, single-cycle
// valid pulse towards the LSU, drain window before the LSU stall is honoured,
// and PC redirect from any state.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  wishbone_if.master  wishbone_bus,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_instruction_valid
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [CNT_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic               redirect_pending_reg, redirect_pending_next;
  logic [31:0]        instruction_reg, instruction_next;
  logic [31:0]        pc_out_reg, pc_out_next;
  logic               valid_reg, valid_next;
  logic               strobe_reg, strobe_next;
  logic [31:0]        address_reg, address_next;

  // Redirect target with the byte-offset bits cleared.
  logic [31:0] branch_pc;
  assign branch_pc = i_branch_target & 32'hFFFF_FFFC;

  // Registered state; reset also drops any in-flight bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= IDLE;
      pc_reg               <= RESET_PC;
      drain_cnt_reg        <= '0;
      redirect_pending_reg <= 1'b0;
      instruction_reg      <= NOP;
      pc_out_reg           <= RESET_PC;
      valid_reg            <= 1'b0;
      strobe_reg           <= 1'b0;
      address_reg          <= 32'h0;
    end else begin
      state_reg            <= state_next;
      pc_reg               <= pc_next;
      drain_cnt_reg        <= drain_cnt_next;
      redirect_pending_reg <= redirect_pending_next;
      instruction_reg      <= instruction_next;
      pc_out_reg           <= pc_out_next;
      valid_reg            <= valid_next;
      strobe_reg           <= strobe_next;
      address_reg          <= address_next;
    end
  end

  // Next-state, bus and output decode; a branch always overrides pc+4.
  always_comb begin
    state_next            = state_reg;
    pc_next               = pc_reg;
    drain_cnt_next        = drain_cnt_reg;
    redirect_pending_next = redirect_pending_reg;
    instruction_next      = instruction_reg;
    pc_out_next           = pc_out_reg;
    valid_next            = 1'b0;
    strobe_next           = strobe_reg;
    address_next          = address_reg;

    case (state_reg)
      IDLE: begin
        pc_next      = i_branch_taken ? branch_pc : pc_reg;
        address_next = i_branch_taken ? branch_pc : pc_reg;
        strobe_next  = 1'b1;
        state_next   = FETCH;
      end

      FETCH: begin
        if (wishbone_bus.ack) begin
          strobe_next  = 1'b0;
          address_next = 32'h0;
          if (redirect_pending_reg || i_branch_taken) begin
            // Data belongs to the abandoned path; pc already (or now) holds the target.
            redirect_pending_next = 1'b0;
            pc_next               = i_branch_taken ? branch_pc : pc_reg;
            state_next            = IDLE;
          end else begin
            instruction_next = wishbone_bus.data_out;
            pc_out_next      = pc_reg;
            valid_next       = 1'b1;
            pc_next          = pc_reg + 32'd4;
            drain_cnt_next   = DRAIN_LOAD;
            state_next       = DRAIN;
          end
        end else if (i_branch_taken) begin
          // Let the current bus cycle finish, then throw its data away.
          redirect_pending_next = 1'b1;
          pc_next               = branch_pc;
        end
      end

      DRAIN: begin
        drain_cnt_next = (drain_cnt_reg == '0) ? '0 : drain_cnt_reg - CNT_W'(1);
        if (i_branch_taken) pc_next = branch_pc;
        if ((drain_cnt_next == '0) && !i_stall) state_next = IDLE;
      end

      default: begin
        state_next  = IDLE;
        strobe_next = 1'b0;
      end
    endcase
  end

  assign wishbone_bus.strobe       = strobe_reg;
  assign wishbone_bus.cycle        = strobe_reg;
  assign wishbone_bus.address      = address_reg;
  assign wishbone_bus.select       = 4'b1111;
  assign wishbone_bus.write_enable = 1'b0;
  assign wishbone_bus.data_in      = 32'h0;

  assign o_instruction       = instruction_reg;
  assign o_pc                = pc_out_reg;
  assign o_instruction_valid = valid_reg;

endmodule
